// File: rtl/wrd_check.sv
// Read-data checker: realigns expected data (= read address) to the memory read
// latency, counts mismatches and reports per-pass status. Optional watchdog: WRD_CHECK_TIMEOUT_EN.
module wrd_check #(
  parameter int ADDR_WIDTH    = 18,
  parameter int DATA_WIDTH    = 32,
  parameter int RD_LATENCY    = 1,
  parameter int ERR_CNT_WIDTH = 16,
  parameter int TIMEOUT       = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rd_en,
  input  logic [ADDR_WIDTH-1:0]    rd_addr,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  input  logic                     clr,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic                     err_flag,
  output logic [ADDR_WIDTH-1:0]    first_err_addr,
  output logic [DATA_WIDTH-1:0]    first_err_data,
  output logic                     pass_done,
  output logic                     pass_ok,
  output logic                     timeout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] PASS_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [RD_LATENCY-1:0]    r_pipeValid;
  logic [ADDR_WIDTH-1:0]    r_pipeAddr [RD_LATENCY];
  state_t                   r_state;
  logic [ADDR_WIDTH:0]      r_passCnt;
  logic                     r_passErr;
  logic [ERR_CNT_WIDTH-1:0] r_errCnt;
  logic                     r_errFlag;
  logic [ADDR_WIDTH-1:0]    r_firstAddr;
  logic [DATA_WIDTH-1:0]    r_firstData;
  logic                     r_passDone;
  logic                     r_passOk;

  logic                     w_cmpValid;
  logic [ADDR_WIDTH-1:0]    w_cmpAddr;
  logic [DATA_WIDTH-1:0]    w_expData;
  logic                     w_mismatch;
  logic [ADDR_WIDTH:0]      w_passCntInc;
  logic                     w_passErrNext;
  logic                     w_idleHit;

  // Delay line carrying the read address alongside its valid bit until the data returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipeValid <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_pipeAddr[i] <= '0;
    end else if (clr) begin
      r_pipeValid <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_pipeAddr[i] <= '0;
    end else begin
      r_pipeValid[0] <= rd_en;
      r_pipeAddr[0]  <= rd_addr;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipeValid[i] <= r_pipeValid[i-1];
        r_pipeAddr[i]  <= r_pipeAddr[i-1];
      end
    end
  end

  assign w_cmpValid = r_pipeValid[RD_LATENCY-1];
  assign w_cmpAddr  = r_pipeAddr[RD_LATENCY-1];

  if (DATA_WIDTH > ADDR_WIDTH) begin : g_expZext
    assign w_expData = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, w_cmpAddr};
  end else begin : g_expTrunc
    assign w_expData = w_cmpAddr[DATA_WIDTH-1:0];
  end

  assign w_mismatch    = w_cmpValid && (rd_data != w_expData);
  assign w_passCntInc  = r_passCnt + CNT_ONE;
  assign w_passErrNext = r_passErr | w_mismatch;

`ifdef WRD_CHECK_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  logic [IDLE_W-1:0] r_idleCnt;
  logic              r_timeout;
  logic [IDLE_W-1:0] w_idleInc;

  assign w_idleInc = r_idleCnt + 1'b1;
  assign w_idleHit = (r_state == RUN) && !w_cmpValid && (w_idleInc == IDLE_W'(TIMEOUT));

  // Watchdog only runs while a pass is in progress; any compare restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idleCnt <= '0;
      r_timeout <= 1'b0;
    end else if (clr) begin
      r_idleCnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == RUN && !w_cmpValid && !w_idleHit) r_idleCnt <= w_idleInc;
      else                                             r_idleCnt <= '0;
      if (w_idleHit) r_timeout <= 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  logic w_unused;
  assign w_unused  = (TIMEOUT != 0);
  assign w_idleHit = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_passCnt   <= '0;
      r_passErr   <= 1'b0;
      r_errCnt    <= '0;
      r_errFlag   <= 1'b0;
      r_firstAddr <= '0;
      r_firstData <= '0;
      r_passDone  <= 1'b0;
      r_passOk    <= 1'b0;
    end else if (clr) begin
      r_state     <= IDLE;
      r_passCnt   <= '0;
      r_passErr   <= 1'b0;
      r_errCnt    <= '0;
      r_errFlag   <= 1'b0;
      r_firstAddr <= '0;
      r_firstData <= '0;
      r_passDone  <= 1'b0;
      r_passOk    <= 1'b0;
    end else begin
      r_passDone <= 1'b0;
      r_passOk   <= 1'b0;
      if (w_mismatch) begin
        if (r_errCnt != '1) r_errCnt <= r_errCnt + 1'b1;
        if (!r_errFlag) begin
          r_errFlag   <= 1'b1;
          r_firstAddr <= w_cmpAddr;
          r_firstData <= rd_data;
        end
      end
      case (r_state)
        IDLE: begin
          if (w_cmpValid) begin
            r_state   <= RUN;
            r_passCnt <= CNT_ONE;
            r_passErr <= w_mismatch;
          end
        end
        RUN: begin
          if (w_cmpValid) begin
            if (w_passCntInc == PASS_LEN) begin
              r_state    <= DONE;
              r_passDone <= 1'b1;
              r_passOk   <= ~w_passErrNext;
              r_passCnt  <= '0;
              r_passErr  <= 1'b0;
            end else begin
              r_passCnt <= w_passCntInc;
              r_passErr <= w_passErrNext;
            end
          end else if (w_idleHit) begin
            r_state   <= IDLE;
            r_passCnt <= '0;
            r_passErr <= 1'b0;
          end
        end
        DONE: begin
          // A compare landing here opens the next pass.
          r_state   <= RUN;
          r_passCnt <= w_cmpValid ? CNT_ONE : '0;
          r_passErr <= w_mismatch;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign err_cnt        = r_errCnt;
  assign err_flag       = r_errFlag;
  assign first_err_addr = r_firstAddr;
  assign first_err_data = r_firstData;
  assign pass_done      = r_passDone;
  assign pass_ok        = r_passOk;

endmodule

// File: tb/tb_wrd_check.sv
// Directed self-checking bench for wrd_check (ADDR_WIDTH=4, DATA_WIDTH=8, RD_LATENCY=2).
// Optional watchdog checks follow WRD_CHECK_TIMEOUT_EN.
module tb_wrd_check;

   localparam int AW  = 4;
   localparam int DW  = 8;
   localparam int LAT = 2;
   localparam int EW  = 2;
   localparam int TO  = 8;
`ifdef WRD_CHECK_TIMEOUT_EN
   localparam int GAP = 5;
`else
   localparam int GAP = 16;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          clr;
   logic [EW-1:0] err_cnt;
   logic          err_flag;
   logic [AW-1:0] first_err_addr;
   logic [DW-1:0] first_err_data;
   logic          pass_done;
   logic          pass_ok;
   logic          timeout;

   logic [DW-1:0] dataNext;
   logic [DW-1:0] memPipe1;

   int   total = 0;
   int   bad = 0;
   int   passDoneCnt = 0;
   int   startCnt;
   logic lastPassOk = 1'b0;

   wrd_check #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .RD_LATENCY(LAT),
      .ERR_CNT_WIDTH(EW),
      .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rd_en(rd_en),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .clr(clr),
      .err_cnt(err_cnt),
      .err_flag(err_flag),
      .first_err_addr(first_err_addr),
      .first_err_data(first_err_data),
      .pass_done(pass_done),
      .pass_ok(pass_ok),
      .timeout(timeout)
   );

   // Free-running clock, 10 ns period.
   always #5 clk = ~clk;

   // Memory model: returns the data presented with a read two cycles later.
   always @(posedge clk) begin
      memPipe1 <= dataNext;
      rd_data  <= memPipe1;
   end

   // Tally pass_done pulses away from the active edge.
   always @(negedge clk) begin
      if (pass_done) begin
         passDoneCnt++;
         lastPassOk = pass_ok;
      end
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish expected finish");
      $fatal(1, "[TB] simulation time limit");
   end

   task checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of generator/memory inputs, return 1 ns after the edge.
   task applyStimulus(input logic en, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      rd_en    = en;
      rd_addr  = addr;
      dataNext = data;
      @(posedge clk);
      #1;
   endtask

   task idleCycles(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, '0, '0);
   endtask

   task doClear();
      clr = 1'b1;
      applyStimulus(1'b0, '0, '0);
      clr = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      clr      = 1'b0;
      rd_en    = 1'b0;
      rd_addr  = '0;
      dataNext = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset err_cnt", err_cnt, 0);
      checkOutput("reset err_flag", err_flag, 0);
      checkOutput("reset first_addr", first_err_addr, 0);
      checkOutput("reset first_data", first_err_data, 0);
      checkOutput("reset pass_done", pass_done, 0);
      checkOutput("reset pass_ok", pass_ok, 0);
      checkOutput("reset timeout", timeout, 0);
      rst_n = 1'b1;
      idleCycles(2);

      $display("[TB] clean pass");
      startCnt = passDoneCnt;
      for (int a = 0; a < 16; a++) applyStimulus(1'b1, AW'(a), DW'(a));
      idleCycles(2);
      checkOutput("clean pass_done", pass_done, 1);
      checkOutput("clean pass_ok", pass_ok, 1);
      checkOutput("clean err_cnt", err_cnt, 0);
      checkOutput("clean err_flag", err_flag, 0);
      checkOutput("clean timeout", timeout, 0);
      idleCycles(1);
      checkOutput("clean pulse width", pass_done, 0);
      checkOutput("clean pass count", passDoneCnt - startCnt, 1);
      doClear();

      $display("[TB] gapped back-to-back passes");
      startCnt = passDoneCnt;
      for (int a = 0; a < 8; a++) applyStimulus(1'b1, AW'(a), DW'(a));
      idleCycles(GAP);
      checkOutput("gap no early done", passDoneCnt - startCnt, 0);
      for (int a = 8; a < 16; a++) applyStimulus(1'b1, AW'(a), DW'(a));
      for (int a = 0; a < 16; a++) applyStimulus(1'b1, AW'(a), DW'(a));
      idleCycles(3);
      checkOutput("gap pass count", passDoneCnt - startCnt, 2);
      checkOutput("gap last pass_ok", lastPassOk, 1);
      checkOutput("gap err_cnt", err_cnt, 0);
      doClear();

      $display("[TB] single error");
      startCnt = passDoneCnt;
      for (int a = 0; a < 16; a++) begin
         applyStimulus(1'b1, AW'(a), (a == 5) ? 8'hFF : DW'(a));
         if (a == 6) checkOutput("single flag latency", err_flag, 0);
         if (a == 7) begin
            checkOutput("single err_cnt", err_cnt, 1);
            checkOutput("single err_flag", err_flag, 1);
            checkOutput("single first_addr", first_err_addr, 5);
            checkOutput("single first_data", first_err_data, 8'hFF);
         end
      end
      idleCycles(2);
      checkOutput("single pass_done", pass_done, 1);
      checkOutput("single pass_ok", pass_ok, 0);
      doClear();

      $display("[TB] saturation");
      for (int a = 0; a < 16; a++) begin
         logic [DW-1:0] d;
         d = DW'(a);
         if (a == 3 || a == 4 || a == 8 || a == 9 || a == 10 || a == 12) d = ~d;
         applyStimulus(1'b1, AW'(a), d);
      end
      idleCycles(2);
      checkOutput("sat err_cnt", err_cnt, 3);
      checkOutput("sat first_addr", first_err_addr, 3);
      checkOutput("sat first_data", first_err_data, 8'hFC);
      checkOutput("sat pass_ok", pass_ok, 0);
      doClear();

      $display("[TB] reset mid-pass");
      for (int a = 0; a < 7; a++) applyStimulus(1'b1, AW'(a), (a == 2) ? 8'h55 : DW'(a));
      checkOutput("rst pre err_flag", err_flag, 1);
      startCnt = passDoneCnt;
      rd_en = 1'b0;
      rst_n = 1'b0;
      #1;
      checkOutput("rst async err_cnt", err_cnt, 0);
      checkOutput("rst async err_flag", err_flag, 0);
      checkOutput("rst async first_addr", first_err_addr, 0);
      checkOutput("rst async first_data", first_err_data, 0);
      idleCycles(2);
      rst_n = 1'b1;
      idleCycles(20);
      checkOutput("rst no pass_done", passDoneCnt - startCnt, 0);

      $display("[TB] clear after mismatch");
      for (int a = 0; a < 4; a++) applyStimulus(1'b1, AW'(a), (a == 1) ? 8'hAA : DW'(a));
      idleCycles(3);
      checkOutput("clr pre err_cnt", err_cnt, 1);
      checkOutput("clr pre first_data", first_err_data, 8'hAA);
      doClear();
      checkOutput("clr err_cnt", err_cnt, 0);
      checkOutput("clr err_flag", err_flag, 0);
      checkOutput("clr first_addr", first_err_addr, 0);
      startCnt = passDoneCnt;
      for (int a = 0; a < 16; a++) applyStimulus(1'b1, AW'(a), DW'(a));
      idleCycles(2);
      checkOutput("clr fresh pass_done", pass_done, 1);
      checkOutput("clr fresh pass_ok", pass_ok, 1);
      idleCycles(1);
      checkOutput("clr fresh pass count", passDoneCnt - startCnt, 1);
      doClear();

      $display("[TB] watchdog");
      for (int a = 0; a < 3; a++) applyStimulus(1'b1, AW'(a), DW'(a));
      idleCycles(20);
`ifdef WRD_CHECK_TIMEOUT_EN
      checkOutput("timeout set", timeout, 1);
`else
      checkOutput("timeout stays low", timeout, 0);
`endif
      doClear();
      checkOutput("timeout after clr", timeout, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
